attack_resolver: RTL and testbench

//  Consumer end of the per-player frame pipeline. Waits for both player next-state calculators to finish a frame
//  (done_gen), samples each player's state/index/position, and decides whether a KICK or GRAB connected.

---
 rtl/attack_resolver.sv | 181 ++++++++++++++++++
 tb/tb_attack_resolver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_resolver.sv
// Frame-pipeline consumer: waits for both players' done_gen, samples their state and
// position, decides whether a kick or grab connected, and latches a sticky round result.
module attack_resolver #(
    parameter int STATE_DEPTH        = 3,
    parameter int SPRITE_INDEX_DEPTH = 4,
    parameter int POSITION_DEPTH     = 10,
    parameter int PLAYER_WIDTH       = 64,
    parameter int KICK_RANGE         = 32,
    parameter int GRAB_RANGE         = 12,
    parameter int KICK_ACTIVE_IDX    = 3,
    parameter int GRAB_ACTIVE_IDX    = 2,
    parameter int TIMEOUT_CYCLES     = 255,
    parameter int ST_KICK            = 3,
    parameter int ST_GRAB            = 4,
    parameter int ST_BLOCK           = 5
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          frame_clk,
    input  logic [STATE_DEPTH-1:0]        p1_state,
    input  logic [SPRITE_INDEX_DEPTH-1:0] p1_index,
    input  logic [POSITION_DEPTH-1:0]     p1_position,
    input  logic                          p1_done_gen,
    input  logic [STATE_DEPTH-1:0]        p2_state,
    input  logic [SPRITE_INDEX_DEPTH-1:0] p2_index,
    input  logic [POSITION_DEPTH-1:0]     p2_position,
    input  logic                          p2_done_gen,
    output logic                          p1_attack_connected,
    output logic                          p2_attack_connected,
    output logic                          result_valid,
    output logic                          round_over,
    output logic                          timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = POSITION_DEPTH + 1;

    localparam logic [STATE_DEPTH-1:0]        KICK_CODE  = STATE_DEPTH'(ST_KICK);
    localparam logic [STATE_DEPTH-1:0]        GRAB_CODE  = STATE_DEPTH'(ST_GRAB);
    localparam logic [STATE_DEPTH-1:0]        BLOCK_CODE = STATE_DEPTH'(ST_BLOCK);
    localparam logic [SPRITE_INDEX_DEPTH-1:0] KICK_IDX   = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_IDX);
    localparam logic [SPRITE_INDEX_DEPTH-1:0] GRAB_IDX   = SPRITE_INDEX_DEPTH'(GRAB_ACTIVE_IDX);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_RESOLVE} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            fr_meta_q, fr_sync_q, fr_prev_q;
    logic                            fr_edge;
    logic                            p1c_q, p1c_d, p2c_q, p2c_d;
    logic                            round_q, round_d, valid_q, valid_d, terr_q, terr_d;
    logic                            capture;
    logic [STATE_DEPTH-1:0]          p1_state_q, p2_state_q;
    logic [SPRITE_INDEX_DEPTH-1:0]   p1_index_q, p2_index_q;
    logic [POSITION_DEPTH-1:0]       p1_pos_q, p2_pos_q;
    logic [GAP_W-1:0]                p1_end, p2_ext, gap;
    logic                            p1_hit, p2_hit;

    assign fr_edge = fr_sync_q & ~fr_prev_q;

    // Widened by one bit so a left player near the right edge cannot wrap past the opponent.
    assign p1_end = {1'b0, p1_pos_q} + GAP_W'(PLAYER_WIDTH);
    assign p2_ext = {1'b0, p2_pos_q};
    assign gap    = (p2_ext >= p1_end) ? (p2_ext - p1_end) : '0;

    assign p1_hit = ((p1_state_q == KICK_CODE) && (p1_index_q == KICK_IDX) &&
                     (gap <= GAP_W'(KICK_RANGE)) && (p2_state_q != BLOCK_CODE)) ||
                    ((p1_state_q == GRAB_CODE) && (p1_index_q == GRAB_IDX) &&
                     (gap <= GAP_W'(GRAB_RANGE)));
    assign p2_hit = ((p2_state_q == KICK_CODE) && (p2_index_q == KICK_IDX) &&
                     (gap <= GAP_W'(KICK_RANGE)) && (p1_state_q != BLOCK_CODE)) ||
                    ((p2_state_q == GRAB_CODE) && (p2_index_q == GRAB_IDX) &&
                     (gap <= GAP_W'(GRAB_RANGE)));

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1c_d   = p1c_q;
        p2c_d   = p2c_q;
        round_d = round_q;
        terr_d  = terr_q;
        valid_d = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fr_edge) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (fr_edge) begin
                    terr_d = 1'b1;
                    cnt_d  = '0;
                end else if (p1_done_gen && p2_done_gen) begin
                    capture = 1'b1;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        terr_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (fr_edge) begin
                    terr_d  = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    // Results register on entry to RESOLVE so they are visible during it.
                    state_d = S_RESOLVE;
                    valid_d = 1'b1;
                    if (!round_q) begin
                        p1c_d   = p1_hit & ~p2_hit;
                        p2c_d   = p2_hit & ~p1_hit;
                        round_d = p1_hit ^ p2_hit;
                    end
                end
            end
            S_RESOLVE: begin
                if (fr_edge) begin
                    terr_d  = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            fr_meta_q <= 1'b0;
            fr_sync_q <= 1'b0;
            fr_prev_q <= 1'b0;
            p1c_q     <= 1'b0;
            p2c_q     <= 1'b0;
            round_q   <= 1'b0;
            valid_q   <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fr_meta_q <= frame_clk;
            fr_sync_q <= fr_meta_q;
            fr_prev_q <= fr_sync_q;
            p1c_q     <= p1c_d;
            p2c_q     <= p2c_d;
            round_q   <= round_d;
            valid_q   <= valid_d;
            terr_q    <= terr_d;
        end
    end

    // NOTE: sample registers carry no reset; they are only read after a capture has loaded them.
    always_ff @(posedge sys_clk) begin
        if (capture) begin
            p1_state_q <= p1_state;
            p1_index_q <= p1_index;
            p1_pos_q   <= p1_position;
            p2_state_q <= p2_state;
            p2_index_q <= p2_index;
            p2_pos_q   <= p2_position;
        end
    end

    assign p1_attack_connected = p1c_q;
    assign p2_attack_connected = p2c_q;
    assign result_valid        = valid_q;
    assign round_over          = round_q;
    assign timeout_err         = terr_q;

endmodule

// File: tb/tb_attack_resolver.sv
// Scoreboard bench for attack_resolver: directed boundary frames plus randomized frames,
// expected results from a rule-level reference model, checked by an independent monitor.
module tb_attack_resolver;

    localparam int NOTHING = 0;
    localparam int KICK    = 3;
    localparam int GRAB    = 4;
    localparam int BLOCK   = 5;

    logic       sys_clk = 1'b0;
    logic       reset, frame_clk;
    logic [2:0] p1_state, p2_state;
    logic [3:0] p1_index, p2_index;
    logic [9:0] p1_position, p2_position;
    logic       p1_done_gen, p2_done_gen;
    logic       p1_attack_connected, p2_attack_connected;
    logic       result_valid, round_over, timeout_err;

    typedef struct packed {
        logic p1c;
        logic p2c;
        logic ro;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   m_p1c, m_p2c, m_ro, m_terr;

    attack_resolver dut (
        .sys_clk             (sys_clk),
        .reset               (reset),
        .frame_clk           (frame_clk),
        .p1_state            (p1_state),
        .p1_index            (p1_index),
        .p1_position         (p1_position),
        .p1_done_gen         (p1_done_gen),
        .p2_state            (p2_state),
        .p2_index            (p2_index),
        .p2_position         (p2_position),
        .p2_done_gen         (p2_done_gen),
        .p1_attack_connected (p1_attack_connected),
        .p2_attack_connected (p2_attack_connected),
        .result_valid        (result_valid),
        .round_over          (round_over),
        .timeout_err         (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int gap_of(input int left, input int right);
        return (right >= left + 64) ? right - left - 64 : 0;
    endfunction

    function automatic bit hits(input int st, input int ix, input int opp_st, input int gap);
        return (st == KICK && ix == 3 && gap <= 32 && opp_st != BLOCK) ||
               (st == GRAB && ix == 2 && gap <= 12);
    endfunction

    task automatic model_frame(input int s1, input int i1, input int x1,
                               input int s2, input int i2, input int x2);
        int g;
        bit h1, h2;
        g  = gap_of(x1, x2);
        h1 = hits(s1, i1, s2, g);
        h2 = hits(s2, i2, s1, g);
        if (!m_ro) begin
            m_p1c = h1 && !h2;
            m_p2c = h2 && !h1;
            m_ro  = h1 != h2;
        end
        exp_q.push_back('{p1c: m_p1c, p2c: m_p2c, ro: m_ro});
    endtask

    // Monitor: pops one expectation per presented result.
    always @(negedge sys_clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("p1_attack_connected", p1_attack_connected, mon_e.p1c);
                check("p2_attack_connected", p2_attack_connected, mon_e.p2c);
                check("round_over", round_over, mon_e.ro);
            end
        end
    end

    task automatic reset_dut();
        reset       = 1'b1;
        frame_clk   = 1'b0;
        p1_done_gen = 1'b0;
        p2_done_gen = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 reset = 1'b0;
        m_p1c  = 1'b0;
        m_p2c  = 1'b0;
        m_ro   = 1'b0;
        m_terr = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_clk = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 frame_clk = 1'b0;
    endtask

    task automatic do_frame(input int s1, input int i1, input int x1,
                            input int s2, input int i2, input int x2, input bit overrun);
        int lat;
        bit got;
        p1_state    = 3'(s1);
        p1_index    = 4'(i1);
        p1_position = 10'(x1);
        p2_state    = 3'(s2);
        p2_index    = 4'(i2);
        p2_position = 10'(x2);
        p1_done_gen = 1'b0;
        p2_done_gen = 1'b0;
        pulse_frame();
        repeat (4) @(posedge sys_clk);
        #1;
        if (overrun) begin
            pulse_frame();
            repeat (3) @(posedge sys_clk);
            @(negedge sys_clk);
            check("timeout_err_on_overrun", timeout_err, 1);
            m_terr = 1'b1;
            @(posedge sys_clk);
            #1;
        end
        model_frame(s1, i1, x1, s2, i2, x2);
        p1_done_gen = 1'b1;
        p2_done_gen = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge sys_clk);
            if (result_valid === 1'b1) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("result_seen", got, 1);
        if (got) check("result_latency", lat, 3);
        check("timeout_err_after_frame", timeout_err, m_terr);
        @(posedge sys_clk);
        #1;
        p1_done_gen = 1'b0;
        p2_done_gen = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s1, s2, i1, i2, x1, x2;
        reset       = 1'b1;
        frame_clk   = 1'b0;
        p1_state    = '0;
        p2_state    = '0;
        p1_index    = '0;
        p2_index    = '0;
        p1_position = '0;
        p2_position = '0;
        p1_done_gen = 1'b0;
        p2_done_gen = 1'b0;
        reset_dut();
        @(negedge sys_clk);
        check("reset_p1c", p1_attack_connected, 0);
        check("reset_p2c", p2_attack_connected, 0);
        check("reset_valid", result_valid, 0);
        check("reset_round_over", round_over, 0);
        check("reset_timeout_err", timeout_err, 0);
        @(posedge sys_clk);
        #1;

        // Boundary frames that must not connect, then a clash.
        do_frame(KICK, 3, 100, BLOCK, 0, 190, 1'b0);
        do_frame(KICK, 3, 100, NOTHING, 0, 197, 1'b0);
        do_frame(KICK, 2, 100, NOTHING, 0, 190, 1'b0);
        do_frame(GRAB, 2, 100, NOTHING, 0, 177, 1'b0);
        do_frame(KICK, 3, 100, KICK, 3, 150, 1'b0);
        // Grab at gap 12 through a block, then a later p2 hit must be ignored.
        do_frame(GRAB, 2, 100, BLOCK, 0, 176, 1'b0);
        do_frame(NOTHING, 0, 100, KICK, 3, 190, 1'b0);

        // Reset during WAIT clears everything and leaves the FSM idle.
        pulse_frame();
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b1;
        @(posedge sys_clk);
        #1 reset = 1'b0;
        m_p1c = 1'b0; m_p2c = 1'b0; m_ro = 1'b0; m_terr = 1'b0;
        @(negedge sys_clk);
        check("midwait_reset_p1c", p1_attack_connected, 0);
        check("midwait_reset_round_over", round_over, 0);
        check("midwait_reset_valid", result_valid, 0);
        @(posedge sys_clk);
        #1;
        p1_done_gen = 1'b1;
        p2_done_gen = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        p1_done_gen = 1'b0;
        p2_done_gen = 1'b0;

        do_frame(NOTHING, 0, 100, KICK, 3, 196, 1'b0);
        reset_dut();
        do_frame(KICK, 3, 100, NOTHING, 0, 190, 1'b0);

        // Timeout with only p1 done; sticky outputs from the previous hit must hold.
        p1_done_gen = 1'b1;
        p2_done_gen = 1'b0;
        pulse_frame();
        repeat (240) @(posedge sys_clk);
        @(negedge sys_clk);
        check("timeout_not_early", timeout_err, 0);
        repeat (30) @(posedge sys_clk);
        @(negedge sys_clk);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_p1c_held", p1_attack_connected, 1);
        check("timeout_round_over_held", round_over, 1);
        @(posedge sys_clk);
        #1 p1_done_gen = 1'b0;

        // Overrun restart, on a frame whose gap would wrap in 10 bits.
        reset_dut();
        do_frame(KICK, 3, 1000, NOTHING, 0, 1023, 1'b1);

        reset_dut();
        for (int n = 0; n < 40; n++) begin
            s1 = $urandom_range(0, 7);
            s2 = $urandom_range(0, 7);
            i1 = $urandom_range(0, 1) ? ((s1 == KICK) ? 3 : 2) : $urandom_range(0, 15);
            i2 = $urandom_range(0, 1) ? ((s2 == KICK) ? 3 : 2) : $urandom_range(0, 15);
            x1 = $urandom_range(0, 1023);
            x2 = ($urandom_range(0, 3) != 0) ? x1 + $urandom_range(40, 110) : $urandom_range(0, 1023);
            if (x2 > 1023) x2 = 1023;
            do_frame(s1, i1, x1, s2, i2, x2, 1'b0);
            if (m_ro && $urandom_range(0, 1) == 1) reset_dut();
        end

        repeat (5) @(posedge sys_clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
